freq_meter_core: RTL and testbench

Parametrised single-clock frequency measurement engine, successor to the fixed 16/24-bit gated counter path.
- Samples the signal under test into the reference_clock domain and detects its edges.
- Measures in one of two modes: time-gated (count input edges over N reference cycles) or reciprocal (count reference cycles over N input edges).
- Emits each result as a byte-stream frame on a valid/ready port that feeds the SPI bridge directly.

---
 rtl/freq_meter_core.sv | 194 +++++++++++++++++++
 tb/tb_freq_meter_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_core.sv
// Frequency measurement engine: time-gated or reciprocal counting, result streamed as a byte frame.
// Define FREQ_METER_TIMEOUT_EN to build the reciprocal-mode timeout counter.
module freq_meter_core #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GATE_W      = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 28
) (
    input  logic              reference_clock,
    input  logic              reset_n,
    input  logic              signal_in,
    input  logic              capture_enable,
    input  logic              mode,
    input  logic [GATE_W-1:0] gate_len,
    output logic              st_valid,
    output logic [7:0]        st_data,
    input  logic              st_ready,
    output logic              busy
);

    localparam int unsigned NumBytes = 1 + 2 * (CNT_W / 8);
    localparam int unsigned FrameW   = 8 * NumBytes;
    localparam int unsigned IdxW     = $clog2(NumBytes + 1);

    typedef enum logic [1:0] {StIdle, StArm, StMeasure, StSend} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   mode_q;
    logic [GATE_W-1:0]      gate_q;
    logic [GATE_W-1:0]      gate_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_q;
    logic [CNT_W-1:0]       ref_cnt_q;
    logic                   ovf_q;
    logic [FrameW-1:0]      frame_q;
    logic [IdxW-1:0]        bytes_left_q;
    logic                   st_valid_q;

    logic             edge_det;
    logic             xfer;
    logic             start;
    logic             gate_done;
    logic             timeout_hit;
    logic [CNT_W-1:0] edge_cnt_d;
    logic [CNT_W-1:0] ref_cnt_d;
    logic             ovf_d;
    logic [CNT_W-1:0] fin_edge;
    logic [CNT_W-1:0] fin_ref;
    logic             fin_ovf;
    logic [FrameW-1:0] frame_d;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign xfer     = st_valid_q & st_ready;
    assign start    = capture_enable &
                      ((state_q == StIdle) ||
                       ((state_q == StSend) && xfer && (bytes_left_q == IdxW'(1))));
    assign gate_done = (mode_q ? edge_det : 1'b1) && (gate_cnt_q == gate_q - 1'b1);

    // Saturating counter updates; applied only while measuring.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ref_cnt_d  = ref_cnt_q;
        ovf_d      = ovf_q;
        if (&ref_cnt_q) begin
            ovf_d = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + 1'b1;
        end
        if (edge_det) begin
            if (&edge_cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    // Frame is built from the values the counters reach on the final measuring cycle.
    always_comb begin
        fin_edge = edge_cnt_q;
        fin_ref  = ref_cnt_q;
        fin_ovf  = ovf_q;
        if (state_q == StMeasure) begin
            fin_edge = edge_cnt_d;
            fin_ref  = ref_cnt_d;
            fin_ovf  = ovf_d;
        end
        frame_d = {fin_ref, fin_edge, 5'b0, timeout_hit, fin_ovf, mode_q};
    end

`ifdef FREQ_METER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 tmo_run;

    assign tmo_run     = mode_q && ((state_q == StArm) || (state_q == StMeasure));
    assign timeout_hit = tmo_run && (&tmo_q);

    always_ff @(posedge reference_clock) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (!tmo_run) begin
            tmo_q <= '0;
        end else if (!(&tmo_q)) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic unused_timeout_w;
    assign unused_timeout_w = ^TIMEOUT_W;
    assign timeout_hit      = 1'b0;
`endif

    always_ff @(posedge reference_clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            mode_q       <= 1'b0;
            gate_q       <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ref_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            frame_q      <= '0;
            bytes_left_q <= '0;
            st_valid_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (start) begin
                mode_q     <= mode;
                gate_q     <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                gate_cnt_q <= '0;
                edge_cnt_q <= '0;
                ref_cnt_q  <= '0;
                ovf_q      <= 1'b0;
                frame_q    <= '0;
                st_valid_q <= 1'b0;
                state_q    <= mode ? StArm : StMeasure;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StArm: begin
                        if (!capture_enable) begin
                            state_q <= StIdle;
                        end else if (timeout_hit) begin
                            frame_q      <= frame_d;
                            bytes_left_q <= IdxW'(NumBytes);
                            st_valid_q   <= 1'b1;
                            state_q      <= StSend;
                        end else if (edge_det) begin
                            state_q <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        if (!capture_enable) begin
                            state_q <= StIdle;
                        end else begin
                            edge_cnt_q <= edge_cnt_d;
                            ref_cnt_q  <= ref_cnt_d;
                            ovf_q      <= ovf_d;
                            if (!mode_q || edge_det) begin
                                gate_cnt_q <= gate_cnt_q + 1'b1;
                            end
                            if (gate_done || timeout_hit) begin
                                frame_q      <= frame_d;
                                bytes_left_q <= IdxW'(NumBytes);
                                st_valid_q   <= 1'b1;
                                state_q      <= StSend;
                            end
                        end
                    end
                    StSend: begin
                        if (xfer) begin
                            frame_q      <= frame_q >> 8;
                            bytes_left_q <= bytes_left_q - 1'b1;
                            if (bytes_left_q == IdxW'(1)) begin
                                st_valid_q <= 1'b0;
                                state_q    <= StIdle;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign st_valid = st_valid_q;
    assign st_data  = frame_q[7:0];
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_freq_meter_core.sv
// Directed bench for freq_meter_core: a 24-bit and an 8-bit counter instance share the stimulus.
module tb_freq_meter_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        signal_in = 1'b0;
    logic        mode;
    logic [23:0] gate_len;
    logic        cap24, cap8;
    logic        ready_drv;
    logic        sel;
    logic        v24, v8, busy24, busy8;
    logic [7:0]  d24, d8;
    logic        cur_valid, cur_busy;
    logic [7:0]  cur_data;

    int vectors = 0;
    int miscompares = 0;
    int period = 10;
    bit sig_run = 1'b0;
    int phase = 0;

    always #5 clk = ~clk;

    freq_meter_core #(.CNT_W(24), .GATE_W(24), .SYNC_STAGES(2), .TIMEOUT_W(8)) dut (
        .reference_clock(clk),
        .reset_n        (reset_n),
        .signal_in      (signal_in),
        .capture_enable (cap24),
        .mode           (mode),
        .gate_len       (gate_len),
        .st_valid       (v24),
        .st_data        (d24),
        .st_ready       (ready_drv & ~sel),
        .busy           (busy24)
    );

    freq_meter_core #(.CNT_W(8), .GATE_W(24), .SYNC_STAGES(2), .TIMEOUT_W(8)) dut8 (
        .reference_clock(clk),
        .reset_n        (reset_n),
        .signal_in      (signal_in),
        .capture_enable (cap8),
        .mode           (mode),
        .gate_len       (gate_len),
        .st_valid       (v8),
        .st_data        (d8),
        .st_ready       (ready_drv & sel),
        .busy           (busy8)
    );

    assign cur_valid = sel ? v8 : v24;
    assign cur_data  = sel ? d8 : d24;
    assign cur_busy  = sel ? busy8 : busy24;

    // Square wave with the given period, changed on the falling clock edge.
    always @(negedge clk) begin
        if (sig_run) begin
            phase = (phase + 1) % period;
            signal_in = (phase < period / 2);
        end else begin
            phase = 0;
            signal_in = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_meas(input logic s, input logic m, input int g);
        @(negedge clk);
        sel = s;
        mode = m;
        gate_len = g[23:0];
        if (s) cap8 = 1'b1;
        else cap24 = 1'b1;
    endtask

    // Waits for a frame, drops capture_enable once sending, then checks every byte.
    task automatic get_frame(input string tag, input int n, input logic [71:0] exp,
                             input bit toggle, input bit drop_cap, output int send_cycles);
        int guard = 0;
        int got = 0;
        int cyc = 0;
        logic [7:0] held;
        send_cycles = 0;
        while (cur_valid !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " frame start"}, {31'b0, cur_valid}, 32'd1);
        if (cur_valid !== 1'b1) return;
        if (drop_cap) begin
            if (sel) cap8 = 1'b0;
            else cap24 = 1'b0;
        end
        while (got < n && cyc < 64) begin
            ready_drv = toggle ? (cyc % 2 == 0) : 1'b1;
            if (cur_valid === 1'b1) send_cycles++;
            held = cur_data;
            if (ready_drv) begin
                check($sformatf("%s byte%0d", tag, got), {24'b0, cur_data}, {24'b0, exp[8*got +: 8]});
                got++;
            end
            @(negedge clk);
            cyc++;
            if (!ready_drv) begin
                check($sformatf("%s stall valid", tag), {31'b0, cur_valid}, 32'd1);
                check($sformatf("%s stall data", tag), {24'b0, cur_data}, {24'b0, held});
            end
        end
        ready_drv = 1'b0;
        check({tag, " valid after frame"}, {31'b0, cur_valid}, 32'd0);
    endtask

    initial begin
        int sc;
        bit saw_valid;
        reset_n   = 1'b0;
        cap24     = 1'b0;
        cap8      = 1'b0;
        ready_drv = 1'b0;
        sel       = 1'b0;
        mode      = 1'b0;
        gate_len  = '0;
        repeat (3) @(negedge clk);
        check("reset valid24", {31'b0, v24}, 32'd0);
        check("reset data24", {24'b0, d24}, 32'd0);
        check("reset busy24", {31'b0, busy24}, 32'd0);
        check("reset valid8", {31'b0, v8}, 32'd0);
        check("reset data8", {24'b0, d8}, 32'd0);
        check("reset busy8", {31'b0, busy8}, 32'd0);
        reset_n = 1'b1;
        period  = 10;
        sig_run = 1'b1;
        repeat (20) @(negedge clk);

        // Mode 0, gate 1000, period 10: edge 100, ref 1000.
        start_meas(1'b0, 1'b0, 1000);
        @(negedge clk);
        check("t1 busy", {31'b0, busy24}, 32'd1);
        get_frame("t1", 7, 72'h00_0003E8_000064_00, 1'b0, 1'b1, sc);
        check("t1 send cycles", sc, 7);
        check("t1 idle after", {31'b0, busy24}, 32'd0);

        // Mode 1, gate 4, period 10: edge 4, ref 40.
        start_meas(1'b0, 1'b1, 4);
        get_frame("t2", 7, 72'h00_000028_000004_01, 1'b0, 1'b1, sc);

        // Back-pressure: ready toggled every cycle.
        start_meas(1'b0, 1'b0, 1000);
        get_frame("t4", 7, 72'h00_0003E8_000064_00, 1'b1, 1'b1, sc);
        check("t4 send cycles", sc, 13);

        // Abort mid-measurement in mode 1, then a fresh run.
        start_meas(1'b0, 1'b1, 4);
        repeat (20) @(negedge clk);
        cap24 = 1'b0;
        @(negedge clk);
        check("t5 busy after abort", {31'b0, busy24}, 32'd0);
        saw_valid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (v24 === 1'b1) saw_valid = 1'b1;
        end
        check("t5 no frame after abort", {31'b0, saw_valid}, 32'd0);
        start_meas(1'b0, 1'b1, 4);
        get_frame("t5", 7, 72'h00_000028_000004_01, 1'b0, 1'b1, sc);

        // 8-bit counters: no overflow, then saturation.
        period = 2;
        repeat (10) @(negedge clk);
        start_meas(1'b1, 1'b0, 200);
        get_frame("t3a", 3, 72'hC86400, 1'b0, 1'b1, sc);
        start_meas(1'b1, 1'b0, 600);
        get_frame("t3b", 3, 72'hFFFF02, 1'b0, 1'b1, sc);

        // gate_len 0 behaves as 1, with a quiet input.
        sig_run = 1'b0;
        repeat (10) @(negedge clk);
        start_meas(1'b0, 1'b0, 0);
        get_frame("gate0", 7, 72'h00_000001_000000_00, 1'b0, 1'b1, sc);

`ifdef FREQ_METER_TIMEOUT_EN
        // Mode 1 with no input edges ends by timeout.
        start_meas(1'b0, 1'b1, 4);
        get_frame("t6", 7, 72'h00_000000_000000_05, 1'b0, 1'b1, sc);
`endif

        // Reset in the middle of a frame drops it.
        sig_run = 1'b1;
        period = 10;
        start_meas(1'b0, 1'b0, 30);
        repeat (40) @(negedge clk);
        check("rst frame pending", {31'b0, v24}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst valid dropped", {31'b0, v24}, 32'd0);
        check("rst busy", {31'b0, busy24}, 32'd0);
        reset_n = 1'b1;
        cap24 = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
